// File: rtl/kyber_pkg.sv
// Shared constants and types for the modular-arithmetic datapath (q = 3329).
package kyber_pkg;

  localparam int WIDTH         = 12;
  localparam int PRIME         = 3329;
  // Barrett reduction: qhat = (p * BARRETT_CONST) >> BARRETT_K, with p < 2^24
  localparam int BARRETT_K     = 24;
  localparam int BARRETT_CONST = (1 << BARRETT_K) / PRIME;  // 5039
  localparam int MM_LAT        = 3;

  typedef logic [WIDTH-1:0] coeff_t;

endpackage

// File: rtl/mult_mod.sv
// Three-stage pipelined Barrett modular multiplier: mod_prod = (a*b) mod q,
// valid MM_LAT cycles after a/b are sampled. Datapath flops carry no reset.
module mult_mod
  import kyber_pkg::*;
(
  input  logic   clk,
  input  coeff_t a,
  input  coeff_t b,
  output coeff_t mod_prod
);

  localparam int PW = 2 * WIDTH;   // full product width
  localparam int QW = 13;          // quotient estimate width
  localparam int MW = PW + QW;     // product * constant width
  localparam int RW = WIDTH + 2;   // remainder before final correction (< 2q)

  logic [PW-1:0] prod_d, prod_q;
  logic [MW-1:0] mprod;
  logic [QW-1:0] qhat;
  logic [RW-1:0] rem_d, rem_q;
  coeff_t        mod_prod_d, mod_prod_q;

  // Stage datapath: full product, Barrett estimate, final conditional subtract.
  // With p < 2^24 the estimate is short by at most one q, so a single
  // correction suffices even for out-of-range operands.
  always_comb begin
    prod_d     = PW'(a) * PW'(b);
    mprod      = MW'(prod_q) * MW'(BARRETT_CONST);
    qhat       = QW'(mprod >> BARRETT_K);
    rem_d      = RW'(prod_q - PW'(qhat) * PW'(PRIME));
    mod_prod_d = WIDTH'((rem_q >= RW'(PRIME)) ? rem_q - RW'(PRIME) : rem_q);
  end

  // Pipeline registers, advancing every cycle.
  always_ff @(posedge clk) begin
    prod_q     <= prod_d;
    rem_q      <= rem_d;
    mod_prod_q <= mod_prod_d;
  end

  assign mod_prod = mod_prod_q;

endmodule

// File: rtl/mult_mod_arbiter_rr_grant.sv
// Round-robin grant with lock override: a locked owner that still requests
// wins; otherwise scan from rr_ptr upward modulo N_REQ.
module rr_grant #(
  parameter int N_REQ = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             locked,
  input  logic [ID_W-1:0]  lock_owner,
  output logic [N_REQ-1:0] grant
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // One-hot grant, zero when nobody requests.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (locked && req[lock_owner]) begin
      grant[lock_owner] = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
        idx = sum[ID_W-1:0];
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_mod_arbiter.sv
// Shares one pipelined mult_mod among N_REQ requesters. At most one issue per
// cycle; an {valid,id} tag shift register routes each result back to its
// issuer exactly MM_LAT cycles after acceptance. No stall, no backpressure.
module mult_mod_arbiter #(
  parameter int N_REQ  = 3,
  parameter int WIDTH  = kyber_pkg::WIDTH,   // must equal kyber_pkg::WIDTH
  parameter int MM_LAT = kyber_pkg::MM_LAT,  // must equal mult_mod depth
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(MM_LAT+1)-1:0] inflight,
  output logic                       busy
);

  localparam int STAGES = MM_LAT - 1;
  localparam int CW     = $clog2(MM_LAT + 1);

  logic [ID_W-1:0]             rr_ptr_d, rr_ptr_q;
  logic                        locked_d, locked_q;
  logic [ID_W-1:0]             lock_owner_d, lock_owner_q;
  logic [STAGES:0]             vld_pipe_d, vld_pipe_q;
  logic [STAGES:0][ID_W-1:0]   id_pipe_d, id_pipe_q;
  logic [CW-1:0]               inflight_d, inflight_q;

  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [ID_W-1:0]  gidx;
  logic [WIDTH-1:0] mm_a, mm_b, mm_prod;

  rr_grant #(.N_REQ(N_REQ), .ID_W(ID_W)) u_grant (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .locked     (locked_q),
    .lock_owner (lock_owner_q),
    .grant      (grant)
  );

  assign req_ready = grant;

  // Encode the one-hot grant and mux the winner's operands; idle cycles feed 0.
  always_comb begin
    accept = |grant;
    gidx   = '0;
    mm_a   = '0;
    mm_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx = ID_W'(i);
        mm_a = req_a[i*WIDTH +: WIDTH];
        mm_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  mult_mod u_mm (
    .clk      (clk),
    .a        (mm_a),
    .b        (mm_b),
    .mod_prod (mm_prod)
  );

  // Arbitration state, tag shift register and occupancy count.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    if (accept) begin
      rr_ptr_d     = (gidx == ID_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
      locked_d     = req_lock[gidx];
      lock_owner_d = gidx;
    end else if (locked_q && !req_valid[lock_owner_q]) begin
      locked_d = 1'b0;
    end

    vld_pipe_d[0] = accept;
    id_pipe_d[0]  = gidx;
    for (int s = 1; s <= STAGES; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      id_pipe_d[s]  = id_pipe_q[s-1];
    end

    inflight_d = '0;
    for (int s = 0; s <= STAGES; s++) inflight_d = inflight_d + CW'(vld_pipe_d[s]);
  end

  // Control registers with synchronous reset; in-flight tags are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      locked_q     <= 1'b0;
      lock_owner_q <= '0;
      vld_pipe_q   <= '0;
      id_pipe_q    <= '0;
      inflight_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      vld_pipe_q   <= vld_pipe_d;
      id_pipe_q    <= id_pipe_d;
      inflight_q   <= inflight_d;
    end
  end

  // Route the retiring result to its issuer.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      if (vld_pipe_q[STAGES] && id_pipe_q[STAGES] == ID_W'(i)) rsp_valid[i] = 1'b1;
  end

  assign rsp_data = mm_prod;
  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0) | (|req_valid);

endmodule

// File: tb/tb_mult_mod_arbiter.sv
// Scoreboard bench for mult_mod_arbiter: a reference arbiter picks the
// expected grant, pushes (id, a*b mod q, due cycle) and the monitor pops.
module tb_mult_mod_arbiter;
  localparam int N = 3, W = 12, LAT = 3, Q = 3329;

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_lock = '0, req_ready, rsp_valid;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0]   rsp_data;
  logic [1:0]     inflight;
  logic           busy;

  always #5 clk = ~clk;

  mult_mod_arbiter #(.N_REQ(N), .WIDTH(W), .MM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .inflight(inflight), .busy(busy)
  );

  typedef struct { int id; int data; int due; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  int m_ptr = 0, m_owner = 0;
  bit m_locked = 0;
  int wait_cnt[N];
  logic [N-1:0] last_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (m_locked && v[m_owner]) return m_owner;
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack(input int x0, input int x1, input int x2);
    logic [N*W-1:0] r;
    r = {W'(x2), W'(x1), W'(x0)};
    return r;
  endfunction

  // One clock cycle: drive, check outputs against model, advance model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lk,
                      input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    exp_t e;
    int g, av, bv;
    @(negedge clk);
    req_valid = v; req_lock = lk; req_a = a; req_b = b;
    #1;
    chk("inflight", inflight, sb.size());
    chk("inflight_max", (inflight <= LAT), 1);
    chk("busy", busy, (sb.size() != 0 || v != 0));
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, 1 << e.id);
      chk("rsp_data", rsp_data, e.data);
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
    g = model_grant(v);
    last_ready = req_ready;
    chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    for (int i = 0; i < N; i++) begin
      if (!v[i]) wait_cnt[i] = 0;
      else if (i == g) begin
        chk("starve", (wait_cnt[i] <= N-1), 1);
        wait_cnt[i] = 0;
      end else if (m_locked && v[m_owner]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
    end
    if (g >= 0) begin
      av = int'(a[g*W +: W]);
      bv = int'(b[g*W +: W]);
      e.id = g; e.data = (av * bv) % Q; e.due = cyc + LAT;
      sb.push_back(e);
      m_ptr = (g + 1) % N; m_locked = lk[g]; m_owner = g;
    end else if (m_locked && !v[m_owner]) begin
      m_locked = 0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_lock = '0;
    repeat (n) @(posedge clk);
    cyc += n;
    #1 rst = 1'b0;
    sb.delete();
    m_ptr = 0; m_locked = 0; m_owner = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    do_reset(2);

    // reset state then a single op from requester 1
    idle(1);
    step(3'b010, 3'b000, pack(0, 1234, 0), pack(0, 2345, 0));
    chk("single_ready", last_ready, 3'b010);
    idle(5);

    // boundary operands back-to-back from requester 0
    step(3'b001, 3'b000, pack(3328, 0, 0), pack(3328, 0, 0));
    step(3'b001, 3'b000, pack(0, 0, 0),    pack(3328, 0, 0));
    step(3'b001, 3'b000, pack(1, 0, 0),    pack(3328, 0, 0));
    idle(5);

    // reset while three ops are in flight; nothing may come back
    step(3'b111, 3'b000, pack(11, 22, 33), pack(44, 55, 66));
    step(3'b111, 3'b000, pack(11, 22, 33), pack(44, 55, 66));
    step(3'b111, 3'b000, pack(11, 22, 33), pack(44, 55, 66));
    do_reset(1);
    idle(5);
    step(3'b100, 3'b000, pack(0, 0, 17), pack(0, 0, 3000));
    idle(4);

    // round-robin rotation with everyone requesting
    for (int k = 0; k < 6; k++) begin
      step(3'b111, 3'b000, pack(100+k, 200+k, 300+k), pack(1000+k, 2000+k, 3000+k));
      chk("rr_order", last_ready, 1 << (k % 3));
    end
    idle(4);

    // lock: four beats to requester 2, release on the fourth
    step(3'b100, 3'b100, pack(5, 6, 7), pack(8, 9, 10));
    chk("lock_beat", last_ready, 3'b100);
    for (int k = 0; k < 3; k++) begin
      step(3'b111, (k == 2) ? 3'b000 : 3'b100, pack(5, 6, 3328-k), pack(8, 9, 3327));
      chk("lock_beat", last_ready, 3'b100);
    end
    step(3'b111, 3'b000, pack(12, 13, 14), pack(15, 16, 17));
    chk("lock_next", last_ready, 3'b001);
    idle(5);

    // sustained random traffic
    for (int k = 0; k < 10000; k++) begin
      logic [N-1:0] v, lk;
      v  = N'($urandom_range(0, 7));
      lk = N'($urandom_range(0, 7) & $urandom_range(0, 7));
      step(v, lk,
           pack($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1)),
           pack($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1)));
    end
    idle(LAT + 2);
    chk("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
